// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Hazard/sequencing bundle between the datapath and pipeline_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int CNT_W = 64
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             id_halt;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_branch_taken;
    logic             wb_valid;

    logic             pc_write;
    logic             pc_sel;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             stall;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] retire_count;

    // Datapath side: reports pipeline status, consumes the controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_mem_read, ex_rd, mem_branch_taken, wb_valid,
        input  pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_flush, stall, flush, halted,
               cycle_count, stall_count, flush_count, retire_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
               ex_mem_read, ex_rd, mem_branch_taken, wb_valid,
        output pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_flush, stall, flush, halted,
               cycle_count, stall_count, flush_count, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Load-use/branch hazard control, halt drain sequencing and
//            performance counters for the 5-stage RISC-V pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_W     = 64,
    parameter int DRAIN_CYC = 3
) (
    input  wire            clk,
    input  wire            reset,
    pipeline_ctrl_if.slave bus
);

    localparam int DC_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DC_W-1:0] C_DRAIN_LAST = DC_W'(DRAIN_CYC);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q, retire_cnt_q;

    logic w_lu, w_br;
    logic w_pc_write, w_pc_sel, w_if_id_write;
    logic w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;
    logic w_stall, w_flush;

    assign w_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                   (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));
    assign w_br = bus.mem_branch_taken;

    always_comb begin
        w_pc_write     = 1'b1;
        w_pc_sel       = 1'b0;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_flush = 1'b0;
        w_stall        = 1'b0;
        w_flush        = 1'b0;
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (w_br) begin
                    w_pc_sel       = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_flush        = 1'b1;
                end else if (w_lu) begin
                    w_stall       = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else if (bus.id_halt) begin
                    // Halt moves on to EX; nothing younger is fetched behind it
                    w_pc_write    = 1'b0;
                    w_if_id_flush = 1'b1;
                    state_d       = ST_DRAIN;
                    drain_cnt_d   = DC_W'(1);
                end
            end

            ST_DRAIN: begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                if (w_br) begin
                    // Halt was speculative: redirect and resume normal flow
                    w_pc_write     = 1'b1;
                    w_pc_sel       = 1'b1;
                    w_if_id_write  = 1'b1;
                    w_ex_mem_flush = 1'b1;
                    w_flush        = 1'b1;
                    state_d        = ST_RUN;
                    drain_cnt_d    = '0;
                end else if (drain_cnt_q == C_DRAIN_LAST) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end

            ST_HALT: begin
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
                w_ex_mem_flush = 1'b1;
            end

            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if (state_q != ST_HALT) begin
                cycle_cnt_q  <= cycle_cnt_q  + CNT_W'(1);
                stall_cnt_q  <= stall_cnt_q  + CNT_W'(w_stall);
                flush_cnt_q  <= flush_cnt_q  + CNT_W'(w_flush);
                retire_cnt_q <= retire_cnt_q + CNT_W'(bus.wb_valid);
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.pc_sel       = w_pc_sel;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_flush = w_ex_mem_flush;
    assign bus.stall        = w_stall;
    assign bus.flush        = w_flush;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.cycle_count  = cycle_cnt_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
    assign bus.retire_count = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed bench for pipeline_ctrl (64-bit and 4-bit counter copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int DRAIN_CYC = 3;
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_HALT    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, id_halt, ex_mem_read;
    logic       mem_branch_taken, wb_valid;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Reference model state
    int          m_mode = M_RUN;
    int          m_left = 0;
    logic [63:0] m_cyc = '0, m_st = '0, m_fl = '0, m_ret = '0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(64)) bus64 ();
    pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus64.id_rs1 = id_rs1;           assign bus4.id_rs1 = id_rs1;
    assign bus64.id_rs2 = id_rs2;           assign bus4.id_rs2 = id_rs2;
    assign bus64.id_use_rs1 = id_use_rs1;   assign bus4.id_use_rs1 = id_use_rs1;
    assign bus64.id_use_rs2 = id_use_rs2;   assign bus4.id_use_rs2 = id_use_rs2;
    assign bus64.id_halt = id_halt;         assign bus4.id_halt = id_halt;
    assign bus64.ex_mem_read = ex_mem_read; assign bus4.ex_mem_read = ex_mem_read;
    assign bus64.ex_rd = ex_rd;             assign bus4.ex_rd = ex_rd;
    assign bus64.mem_branch_taken = mem_branch_taken;
    assign bus4.mem_branch_taken  = mem_branch_taken;
    assign bus64.wb_valid = wb_valid;       assign bus4.wb_valid = wb_valid;

    pipeline_ctrl #(.CNT_W(64), .DRAIN_CYC(DRAIN_CYC)) u_dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    pipeline_ctrl #(.CNT_W(4), .DRAIN_CYC(DRAIN_CYC)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    // {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, stall, flush, halted}
    logic [8:0] act64, act4;
    assign act64 = {bus64.pc_write, bus64.pc_sel, bus64.if_id_write, bus64.if_id_flush,
                    bus64.id_ex_flush, bus64.ex_mem_flush, bus64.stall, bus64.flush, bus64.halted};
    assign act4  = {bus4.pc_write, bus4.pc_sel, bus4.if_id_write, bus4.if_id_flush,
                    bus4.id_ex_flush, bus4.ex_mem_flush, bus4.stall, bus4.flush, bus4.halted};

    function automatic logic [8:0] exp_ctrl(input int mode);
        logic lu;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
        if (mode == M_HALT)        return 9'b0_0_0_1_1_1_0_0_1;
        else if (mem_branch_taken) return 9'b1_1_1_1_1_1_0_1_0;
        else if (mode == M_DRAIN)  return 9'b0_0_0_1_1_0_0_0_0;
        else if (lu)               return 9'b0_0_0_0_1_0_1_0_0;
        else if (id_halt)          return 9'b0_0_1_1_0_0_0_0_0;
        else                       return 9'b1_0_1_0_0_0_0_0_0;
    endfunction

    // if_id_write is irrelevant when IF/ID is being flushed out of DRAIN
    function automatic logic [8:0] ctrl_mask(input int mode);
        if (mode == M_DRAIN && mem_branch_taken) return 9'b1_1_0_1_1_1_1_1_1;
        return 9'h1FF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        logic [8:0]  e;
        int          nm, nl;
        logic [63:0] nc, ns, nf, nr;
        e  = exp_ctrl(m_mode);
        nm = m_mode; nl = m_left;
        nc = m_cyc;  ns = m_st; nf = m_fl; nr = m_ret;
        if (reset) begin
            nm = M_RUN; nl = 0;
            nc = '0; ns = '0; nf = '0; nr = '0;
        end else if (m_mode != M_HALT) begin
            nc = nc + 64'd1;
            if (e[2]) ns = ns + 64'd1;
            if (e[1]) nf = nf + 64'd1;
            if (wb_valid) nr = nr + 64'd1;
            if (m_mode == M_RUN) begin
                if (!mem_branch_taken && !e[2] && id_halt) begin
                    nm = M_DRAIN;
                    nl = DRAIN_CYC;
                end
            end else if (mem_branch_taken) begin
                nm = M_RUN;
            end else begin
                nl = nl - 1;
                if (nl == 0) nm = M_HALT;
            end
        end
        m_mode <= nm; m_left <= nl;
        m_cyc <= nc;  m_st <= ns; m_fl <= nf; m_ret <= nr;
    end

    always @(negedge clk) begin
        logic [8:0] e, m;
        if (check_en) begin
            e = exp_ctrl(m_mode);
            m = ctrl_mask(m_mode);
            check("ctrl64", {55'd0, act64 & m}, {55'd0, e & m});
            check("ctrl4",  {55'd0, act4 & m},  {55'd0, e & m});
            check("cycle64",  bus64.cycle_count,  m_cyc);
            check("stall64",  bus64.stall_count,  m_st);
            check("flush64",  bus64.flush_count,  m_fl);
            check("retire64", bus64.retire_count, m_ret);
            check("cycle4",  {60'd0, bus4.cycle_count},  {60'd0, m_cyc[3:0]});
            check("stall4",  {60'd0, bus4.stall_count},  {60'd0, m_st[3:0]});
            check("flush4",  {60'd0, bus4.flush_count},  {60'd0, m_fl[3:0]});
            check("retire4", {60'd0, bus4.retire_count}, {60'd0, m_ret[3:0]});
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_halt = 1'b0;
        ex_mem_read = 1'b0; mem_branch_taken = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_cycle", bus64.cycle_count, 64'd0);
        check("rst_halted", {63'd0, bus64.halted}, 64'd0);
        check("rst_ctrl", {59'd0, bus64.pc_write, bus64.if_id_write, bus64.if_id_flush,
                           bus64.id_ex_flush, bus64.ex_mem_flush}, 64'b11000);
        tick();

        // Load-use via rs1
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        check("lu_stall", {63'd0, bus64.stall}, 64'd1);
        check("lu_pcw", {63'd0, bus64.pc_write}, 64'd0);
        check("lu_idex", {63'd0, bus64.id_ex_flush}, 64'd1);
        tick();
        check("lu_stall_cnt", bus64.stall_count, 64'd1);

        // x0 destination never stalls
        ex_rd = 5'd0; id_rs1 = 5'd0; wb_valid = 1'b1;
        #1;
        check("x0_stall", {63'd0, bus64.stall}, 64'd0);
        check("x0_pcw", {63'd0, bus64.pc_write}, 64'd1);
        tick();
        wb_valid = 1'b0;
        check("x0_stall_cnt", bus64.stall_count, 64'd1);

        // Load-use via rs2, then matching registers that are not read
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        check("rs2_stall", {63'd0, bus64.stall}, 64'd1);
        tick();
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = 5'd7;
        #1;
        check("unused_stall", {63'd0, bus64.stall}, 64'd0);
        tick();

        // Branch beats load-use
        id_use_rs1 = 1'b1; mem_branch_taken = 1'b1;
        #1;
        check("br_ctrl", {55'd0, act64}, {55'd0, 9'b1_1_1_1_1_1_0_1_0});
        tick();
        check("br_flush_cnt", bus64.flush_count, 64'd1);
        check("br_stall_cnt", bus64.stall_count, 64'd2);

        // Halt drain
        idle(); id_halt = 1'b1;
        #1;
        check("halt_ctrl", {62'd0, bus64.pc_write, bus64.if_id_flush}, 64'b01);
        tick();
        idle();
        #1;
        check("drain_ctrl", {55'd0, act64}, {55'd0, 9'b0_0_0_1_1_0_0_0_0});
        tick(); tick();
        wb_valid = 1'b1;
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        mem_branch_taken = 1'b1; id_halt = 1'b1;
        #1;
        check("halted_ctrl", {55'd0, act64}, {55'd0, 9'b0_0_0_1_1_1_0_0_1});
        tick(); tick();
        check("halt_cycle", bus64.cycle_count, 64'd10);
        check("halt_retire", bus64.retire_count, 64'd2);
        check("halt_flush", bus64.flush_count, 64'd1);
        check("halt_cycle4", {60'd0, bus4.cycle_count}, 64'd10);

        // Reset out of HALT
        idle(); reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rhalt_halted", {63'd0, bus64.halted}, 64'd0);
        check("rhalt_cycle", bus64.cycle_count, 64'd0);
        check("rhalt_retire", bus64.retire_count, 64'd0);

        // Wrong-path halt
        id_halt = 1'b1;
        tick();
        idle(); mem_branch_taken = 1'b1;
        #1;
        check("wp_ctrl", {59'd0, bus64.flush, bus64.pc_sel, bus64.pc_write,
                          bus64.ex_mem_flush, bus64.halted}, 64'b11110);
        tick();
        idle();
        #1;
        check("wp_run", {62'd0, bus64.pc_write, bus64.if_id_flush}, 64'b10);
        check("wp_flush_cnt", bus64.flush_count, 64'd1);
        repeat (4) tick();
        check("wp_halted", {63'd0, bus64.halted}, 64'd0);

        // Counter wrap on the 4-bit copy
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (17) tick();
        check("wrap_cycle4", {60'd0, bus4.cycle_count}, 64'd1);
        check("wrap_cycle64", bus64.cycle_count, 64'd17);

        // Reset in the middle of a drain
        id_halt = 1'b1;
        tick();
        idle();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rdrain_cycle", bus64.cycle_count, 64'd0);
        check("rdrain_pcw", {63'd0, bus64.pc_write}, 64'd1);
        repeat (5) tick();
        check("rdrain_halted", {63'd0, bus64.halted}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipelined RISC-V processor.
- Detects load-use hazards and taken branches resolved in MEM, and drives the per-stage write-enable and flush controls plus the top-level stall/flush indicators.
- Sequences program termination: on a halt instruction decoded in ID it drains the pipeline, then freezes it.
- Keeps cycle, stall, flush and retire counters for CPU-time/CPI measurement.

Parameters:
- CNT_W, 64, width of every performance counter.
- DRAIN_CYC, 3, cycles from leaving RUN until HALT; equals the number of stages from ID to WB.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_halt  in  1  ID holds a halt instruction (ecall)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- mem_branch_taken  in  1  branch in MEM resolved taken
- wb_valid  in  1  a non-bubble instruction retires this cycle
- pc_write  out  1  PC register enable
- pc_sel  out  1  1 = load branch target into PC
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_flush  out  1  insert bubble into ID/EX
- ex_mem_flush  out  1  insert bubble into EX/MEM
- stall  out  1  load-use stall active this cycle
- flush  out  1  branch flush active this cycle
- halted  out  1  FSM in HALT
- cycle_count  out  CNT_W  cycles spent in RUN or DRAIN
- stall_count  out  CNT_W  cycles with stall=1
- flush_count  out  CNT_W  cycles with flush=1
- retire_count  out  CNT_W  retired instructions

Behaviour:
- Hazard and flush terms (combinational):
  - lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
  - br = mem_branch_taken.
- FSM states: RUN, DRAIN, HALT. Reset forces RUN and drain_cnt = 0.
- RUN:
  - br=1: flush=1, stall=0, pc_write=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. Flush has priority over lu and id_halt.
  - else lu=1: stall=1, pc_write=0, if_id_write=0, id_ex_flush=1. id_halt is ignored while lu=1.
  - else id_halt=1: move to DRAIN next cycle, drain_cnt = 1. In this cycle pc_write=0 and if_id_flush=1; the halt instruction itself advances to EX.
  - else: pc_write=1, if_id_write=1, all flushes 0.
- DRAIN:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1 (bubbles only).
  - br=1: the halt was on the wrong path. Apply the full RUN flush outputs (pc_write=1, pc_sel=1, flush=1), return to RUN, clear drain_cnt.
  - else drain_cnt increments. When drain_cnt == DRAIN_CYC, enter HALT on the next edge.
- HALT:
  - halted=1; pc_write=0, if_id_write=0.
  - All flush outputs 1; stall=0, flush=0.
  - Inputs are ignored and counters freeze. Only reset leaves HALT.
- Default values: pc_sel=0 and if_id_write=1 unless stated above. stall and flush are 0 except as stated.
- Counters:
  - Registered; they update on the edge following the qualifying cycle.
  - Each wraps modulo 2^CNT_W with no saturation.
  - cycle_count increments every non-HALT cycle.
  - retire_count increments on wb_valid in non-HALT states, including DRAIN.
- Reset values:
  - All counters 0, halted=0.
  - Control outputs take their RUN values for the current inputs. With idle inputs: pc_write=1, if_id_write=1, all flushes 0.
- Reset asserted mid-DRAIN or in HALT returns to RUN on the next edge and zeroes the counters.
- Latency: all control outputs are combinational from the inputs and current state, within the same cycle. State and counters take one cycle.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> stall=1, pc_write=0, id_ex_flush=1 that cycle; stall_count=1 afterwards.
- Zero register: same stimulus with ex_rd=0 -> stall=0 and stall_count stays 0.
- Branch beats stall: mem_branch_taken=1 together with the load-use condition -> flush=1, stall=0, pc_sel=1, all three flush outputs=1; flush_count=1, stall_count=0.
- Halt drain: id_halt=1 in RUN with no hazards, wb_valid pulsed 3 cycles later -> DRAIN for 3 cycles, then halted=1; retire_count includes the halt; cycle_count frozen thereafter.
- Wrong-path halt: id_halt, then mem_branch_taken=1 in the first DRAIN cycle -> flush=1, return to RUN, halted never asserts.
- Counter wrap and reset: CNT_W=4, 17 RUN cycles -> cycle_count=1. Then reset in HALT -> counters 0, halted=0 after one edge.
